// File: rtl/seven_seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_decoder
//
// Watches a time-multiplexed, active-low 7-segment display bus and recovers the
// hex nibble shown on each digit position. Meant to sit beside the display
// driver as an on-chip readback/checker, or as the receive end of any 7-seg
// scan link. The decode table is the exact inverse of the hex->segment encoder.
//
// A sample {an_i, seg_i} must be seen on STABLE_CYCLES consecutive rising edges
// before it is acted upon; each stable interval produces exactly one capture.
//
// Parameters
//   DIGITS         number of multiplexed digit positions (1..16)
//   STABLE_CYCLES  consecutive identical samples required for a capture (>=2)
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   an_i           digit enables, active-low (bit k low selects digit k)
//   seg_i          segments, active-low, bit0=a .. bit6=g
//   err_clr_i      clears err_o (a new error in the same cycle wins)
//   value_o        decoded nibbles, digit k at [4k+3:4k]
//   digit_valid_o  bit k set: last capture of digit k held a legal code
//   frame_valid_o  one-cycle pulse: every digit captured since previous pulse
//   err_o          sticky: illegal segment code, or more than one anode low
//
// Build option
//   SEG_SYNC_EN    when defined, an_i and seg_i pass through a two-flop
//                  synchroniser before the sample register (latency +2).
//                  Leave undefined when the inputs are already synchronous.
// -----------------------------------------------------------------------------
module seven_seg_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an_i,
    input  logic [6:0]            seg_i,
    input  logic                  err_clr_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [DIGITS-1:0]     digit_valid_o,
    output logic                  frame_valid_o,
    output logic                  err_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);

    // Inverse of the hex->segment encoder; result is {legal, nibble}.
    // Input is the active-high gfedcba pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] code);
        logic [4:0] res;
        case (code)
            7'h3F:   res = 5'h10;
            7'h06:   res = 5'h11;
            7'h5B:   res = 5'h12;
            7'h4F:   res = 5'h13;
            7'h66:   res = 5'h14;
            7'h6D:   res = 5'h15;
            7'h7D:   res = 5'h16;
            7'h07:   res = 5'h17;
            7'h7F:   res = 5'h18;
            7'h6F:   res = 5'h19;
            7'h77:   res = 5'h1A;
            7'h7C:   res = 5'h1B;
            7'h39:   res = 5'h1C;
            7'h5E:   res = 5'h1D;
            7'h79:   res = 5'h1E;
            7'h71:   res = 5'h1F;
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    logic [DIGITS-1:0]   an_smp_s;
    logic [6:0]          seg_smp_s;

`ifdef SEG_SYNC_EN
    logic [DIGITS-1:0]   an_s1_r;
    logic [DIGITS-1:0]   an_s2_r;
    logic [6:0]          seg_s1_r;
    logic [6:0]          seg_s2_r;

    // Two-flop synchroniser for asynchronous display pins; reset to a blank bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_s1_r  <= '1;
            an_s2_r  <= '1;
            seg_s1_r <= 7'h00;
            seg_s2_r <= 7'h00;
        end else begin
            an_s1_r  <= an_i;
            an_s2_r  <= an_s1_r;
            seg_s1_r <= seg_i;
            seg_s2_r <= seg_s1_r;
        end
    end

    assign an_smp_s  = an_s2_r;
    assign seg_smp_s = seg_s2_r;
`else
    assign an_smp_s  = an_i;
    assign seg_smp_s = seg_i;
`endif

    logic [DIGITS-1:0]   an_p_r;
    logic [6:0]          seg_p_r;
    logic [CW-1:0]       cnt_r;
    logic [DIGITS-1:0]   seen_r;

    logic                same_s;
    logic                capture_s;
    logic [CW-1:0]       cnt_nxt_s;
    logic [4:0]          low_cnt_s;
    logic [IW-1:0]       low_idx_s;
    logic [4:0]          dec_s;
    logic                err_set_s;
    logic [4*DIGITS-1:0] value_nxt_s;
    logic [DIGITS-1:0]   valid_nxt_s;
    logic [DIGITS-1:0]   seen_nxt_s;
    logic                frame_nxt_s;
    logic                err_nxt_s;

    // Stability counter: restart on any change, arm a single capture on the
    // STABLE_CYCLES-th identical sample, then saturate until the bus changes.
    always_comb begin
        same_s    = (an_smp_s == an_p_r) && (seg_smp_s == seg_p_r);
        capture_s = 1'b0;
        cnt_nxt_s = cnt_r;
        if (!same_s) begin
            cnt_nxt_s = CW'(1);
        end else if (cnt_r < CNT_ARM) begin
            cnt_nxt_s = cnt_r + CW'(1);
        end else if (cnt_r == CNT_ARM) begin
            cnt_nxt_s = CNT_SAT;
            capture_s = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Anode classification: number of low anodes and the position of one of them.
    always_comb begin
        low_cnt_s = 5'd0;
        low_idx_s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!an_smp_s[k]) begin
                low_cnt_s = low_cnt_s + 5'd1;
                low_idx_s = IW'(k);
            end else begin
                low_cnt_s = low_cnt_s;
            end
        end
        dec_s = decode_seg(~seg_smp_s);
    end

    // Capture event: update the selected digit, flag errors, close frames.
    always_comb begin
        value_nxt_s = value_o;
        valid_nxt_s = digit_valid_o;
        seen_nxt_s  = seen_r;
        frame_nxt_s = 1'b0;
        err_set_s   = 1'b0;
        if (capture_s) begin
            if (low_cnt_s == 5'd1) begin
                if (dec_s[4]) begin
                    value_nxt_s[{low_idx_s, 2'b00} +: 4] = dec_s[3:0];
                    valid_nxt_s[low_idx_s]               = 1'b1;
                    seen_nxt_s[low_idx_s]                = 1'b1;
                    if (&seen_nxt_s) begin
                        frame_nxt_s = 1'b1;
                        seen_nxt_s  = '0;
                    end else begin
                        frame_nxt_s = 1'b0;
                    end
                end else begin
                    valid_nxt_s[low_idx_s] = 1'b0;
                    err_set_s              = 1'b1;
                end
            end else if (low_cnt_s > 5'd1) begin
                err_set_s = 1'b1;
            end else begin
                // Blank bus: nothing to capture.
                err_set_s = 1'b0;
            end
        end else begin
            err_set_s = 1'b0;
        end

        if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else if (err_clr_i) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_o;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_p_r        <= '1;
            seg_p_r       <= 7'h00;
            cnt_r         <= '0;
            seen_r        <= '0;
            value_o       <= '0;
            digit_valid_o <= '0;
            frame_valid_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            an_p_r        <= an_smp_s;
            seg_p_r       <= seg_smp_s;
            cnt_r         <= cnt_nxt_s;
            seen_r        <= seen_nxt_s;
            value_o       <= value_nxt_s;
            digit_valid_o <= valid_nxt_s;
            frame_valid_o <= frame_nxt_s;
            err_o         <= err_nxt_s;
        end
    end

endmodule
